// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count_monitor slice.
// State encodings, default widths and the threshold reset value.
package count_monitor_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int EVT_W_DEF = 8;

  // Sliced to CNT_W by users; wide enough for any sane count width.
  localparam logic [31:0] THRESH_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event tally with a sticky overflow flag.
// Clear has priority over increment.
module sat_event_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_count;
  logic         r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc) begin
      if (r_count == MAX)
        r_ovf <= 1'b1;
      else
        r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/count_monitor.sv
// Watches an upstream counter: wrap pulse, wrap tally,
// and an armed one-shot threshold match.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0] thresh_in,
  input  logic             thresh_load,
  input  logic             arm,
  input  logic             clear,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic [EVT_W-1:0] wrap_count,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] THRESH_RST =
    THRESH_ONES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_prev_cnt;
  logic             r_prev_valid;
  logic [CNT_W-1:0] r_thresh;
  logic             r_wrap;
  logic             r_match;
  state_t           r_state;

  logic w_wrap;
  logic w_hit;

  assign w_wrap = r_prev_valid
               && (r_prev_cnt == CNT_MAX)
               && (cnt_in == '0);
  assign w_hit  = (cnt_in == r_thresh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_cnt   <= '0;
      r_prev_valid <= 1'b0;
      r_thresh     <= THRESH_RST;
      r_wrap       <= 1'b0;
    end else begin
      r_prev_cnt   <= cnt_in;
      r_prev_valid <= 1'b1;
      r_wrap       <= w_wrap;
      if (thresh_load)
        r_thresh <= thresh_in;
    end
  end

  // Compare sees r_thresh before any same-edge load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (clear) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE:
            if (arm) r_state <= ARMED;
          ARMED:
            if (w_hit) begin
              r_state <= FIRED;
              r_match <= 1'b1;
            end
          FIRED:
            if (arm) r_state <= ARMED;
          default:
            r_state <= IDLE;
        endcase
      end
    end
  end

  sat_event_counter #(
    .W (EVT_W)
  ) u_tally (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_wrap),
    .i_clr   (clear),
    .o_count (wrap_count),
    .o_ovf   (overflow)
  );

  assign match_pulse = r_match;
  assign wrap_pulse  = r_wrap;
  assign state       = r_state;

endmodule
